// File: rtl/dmem_port_arbiter_pkg.sv
// Package canary_mem_pkg: shared types and constants for the data-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT, COOL)
//   arb_owner_t : current owner of the dmem port (NONE, PIPE, AMO)
//   MASK_FULL   : all-ones byte mask for one 32-bit word; replicated for wider data paths
package canary_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COOL
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_PIPE,
    OWN_AMO
  } arb_owner_t;

  localparam logic [3:0] MASK_FULL = 4'hF;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Interface dmem_port_arbiter_if: the single data-memory/dcache port.
//   dmem_addr   word-aligned request address (arbiter -> memory)
//   dmem_rmask  read byte mask, nonzero for one cycle per request
//   dmem_wmask  write byte mask, nonzero for one cycle per request
//   dmem_wdata  write data
//   dmem_rdata  read data, valid with dmem_resp (memory -> arbiter)
//   dmem_resp   one-cycle completion
// Modports: master (arbiter side), slave (memory side).
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DATA_W/8-1:0] dmem_rmask;
  logic [DATA_W/8-1:0] dmem_wmask;
  logic [DATA_W-1:0]   dmem_wdata;
  logic [DATA_W-1:0]   dmem_rdata;
  logic                dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_arb_perf.sv
// dmem_arb_perf: saturating 32-bit performance counters for the dmem port arbiter.
//   clk, reset       clock, asynchronous active-high reset (clears counters)
//   stall_inc        pipe request waiting while not the owner this cycle
//   amo_op_inc       AMO write completion this cycle
//   perf_pipe_stall  saturating count of stall_inc cycles
//   perf_amo_ops     saturating count of amo_op_inc pulses
module dmem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_inc,
  input  logic        amo_op_inc,
  output logic [31:0] perf_pipe_stall,
  output logic [31:0] perf_amo_ops
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_pipe_stall <= '0;
      perf_amo_ops    <= '0;
    end else begin
      if (stall_inc && !(&perf_pipe_stall)) perf_pipe_stall <= perf_pipe_stall + 32'd1;
      if (amo_op_inc && !(&perf_amo_ops))   perf_amo_ops    <= perf_amo_ops + 32'd1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: arbitrates MEM-stage loads/stores (pipe) and AMO read/write (amo)
// onto one data-memory port. The port stays locked to the AMO unit from its read grant
// until its write-back completes. Each request is issued as a one-cycle mask pulse;
// the completion and read data are routed combinationally back to the owner.
//   clk, reset                 clock, asynchronous active-high reset
//   pipe_rmask/wmask/addr/wdata  pipe request (held until pipe_resp); pipe_rdata/pipe_resp back
//   amo_read/write/addr/wdata    AMO request (held until amo_resp); amo_rdata/amo_resp back
//   dmem                       memory port (dmem_port_arbiter_if.master)
// Optional macro DMEM_ARB_PERF_EN adds perf_pipe_stall[31:0] and perf_amo_ops[31:0].
module dmem_port_arbiter
  import canary_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W/8-1:0] pipe_rmask,
  input  logic [DATA_W/8-1:0] pipe_wmask,
  input  logic [ADDR_W-1:0]   pipe_addr,
  input  logic [DATA_W-1:0]   pipe_wdata,
  output logic [DATA_W-1:0]   pipe_rdata,
  output logic                pipe_resp,
  input  logic                amo_read,
  input  logic                amo_write,
  input  logic [ADDR_W-1:0]   amo_addr,
  input  logic [DATA_W-1:0]   amo_wdata,
  output logic [DATA_W-1:0]   amo_rdata,
  output logic                amo_resp,
  dmem_port_arbiter_if.master dmem
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_pipe_stall,
  output logic [31:0]         perf_amo_ops
`endif
);

  localparam int unsigned MASK_W = DATA_W / 8;
  // Full-word mask for AMO accesses; DATA_W is a multiple of 32
  localparam logic [MASK_W-1:0] AMO_MASK = {(MASK_W / 4){MASK_FULL}};

  arb_state_t          state, state_n;
  arb_owner_t          owner, owner_n;
  logic                amo_lock, amo_lock_n;
  logic [ADDR_W-1:0]   req_addr, req_addr_n;
  logic [MASK_W-1:0]   req_rmask, req_rmask_n;
  logic [MASK_W-1:0]   req_wmask, req_wmask_n;
  logic [DATA_W-1:0]   req_wdata, req_wdata_n;

  logic pipe_req;
  logic amo_req;
  logic amo_is_write;

  assign pipe_req = (|pipe_rmask) || (|pipe_wmask);
  assign amo_req  = amo_read || amo_write;
  // Once locked the only legal follow-up is the write-back, so write wins then.
  assign amo_is_write = amo_write && (amo_lock || !amo_read);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      amo_lock  <= 1'b0;
      req_addr  <= '0;
      req_rmask <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      amo_lock  <= amo_lock_n;
      req_addr  <= req_addr_n;
      req_rmask <= req_rmask_n;
      req_wmask <= req_wmask_n;
      req_wdata <= req_wdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    amo_lock_n  = amo_lock;
    req_addr_n  = req_addr;
    req_rmask_n = req_rmask;
    req_wmask_n = req_wmask;
    req_wdata_n = req_wdata;
    pipe_resp   = 1'b0;
    pipe_rdata  = '0;
    amo_resp    = 1'b0;
    amo_rdata   = '0;

    unique case (state)
      ST_IDLE: begin
        if (amo_req) begin
          owner_n     = OWN_AMO;
          req_addr_n  = {amo_addr[ADDR_W-1:2], 2'b00};
          req_wdata_n = amo_wdata;
          req_rmask_n = amo_is_write ? '0 : AMO_MASK;
          req_wmask_n = amo_is_write ? AMO_MASK : '0;
          if (!amo_is_write) amo_lock_n = 1'b1;
          state_n     = ST_ISSUE;
        end else if (!amo_lock && pipe_req) begin
          owner_n     = OWN_PIPE;
          req_addr_n  = {pipe_addr[ADDR_W-1:2], 2'b00};
          req_wdata_n = pipe_wdata;
          req_wmask_n = pipe_wmask;
          // A store with a stray load mask is treated as a pure store
          req_rmask_n = (|pipe_wmask) ? '0 : pipe_rmask;
          state_n     = ST_ISSUE;
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (state == ST_ISSUE) state_n = ST_WAIT;
        if (dmem.dmem_resp) begin
          state_n = ST_COOL;
          if (owner == OWN_PIPE) begin
            pipe_resp  = 1'b1;
            pipe_rdata = dmem.dmem_rdata;
          end else if (owner == OWN_AMO) begin
            amo_resp  = 1'b1;
            amo_rdata = dmem.dmem_rdata;
            if (|req_wmask) amo_lock_n = 1'b0;
          end
        end
      end

      ST_COOL: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end

      default: begin
        state_n = ST_IDLE;
        owner_n = OWN_NONE;
      end
    endcase
  end

  assign dmem.dmem_addr  = req_addr;
  assign dmem.dmem_wdata = req_wdata;
  assign dmem.dmem_rmask = (state == ST_ISSUE) ? req_rmask : '0;
  assign dmem.dmem_wmask = (state == ST_ISSUE) ? req_wmask : '0;

`ifdef DMEM_ARB_PERF_EN
  logic pipe_stall;
  logic amo_op_done;

  // The grant cycle itself (owner_n becomes PIPE) is not a stall
  assign pipe_stall  = pipe_req && (owner != OWN_PIPE) && (owner_n != OWN_PIPE);
  assign amo_op_done = amo_resp && (|req_wmask);

  dmem_arb_perf u_perf (
    .clk             (clk),
    .reset           (reset),
    .stall_inc       (pipe_stall),
    .amo_op_inc      (amo_op_done),
    .perf_pipe_stall (perf_pipe_stall),
    .perf_amo_ops    (perf_amo_ops)
  );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter.
// Inputs are driven just after each falling edge and outputs sampled 1 time unit later.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  pipe_rmask;
  logic [3:0]  pipe_wmask;
  logic [31:0] pipe_addr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_rdata;
  logic        pipe_resp;
  logic        amo_read;
  logic        amo_write;
  logic [31:0] amo_addr;
  logic [31:0] amo_wdata;
  logic [31:0] amo_rdata;
  logic        amo_resp;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_pipe_stall;
  logic [31:0] perf_amo_ops;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int rd_issues = 0;
  int wr_issues = 0;
  int rd0, wr0;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_rmask (pipe_rmask),
    .pipe_wmask (pipe_wmask),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_resp  (pipe_resp),
    .amo_read   (amo_read),
    .amo_write  (amo_write),
    .amo_addr   (amo_addr),
    .amo_wdata  (amo_wdata),
    .amo_rdata  (amo_rdata),
    .amo_resp   (amo_resp),
    .dmem       (dmem_bus.master)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_pipe_stall (perf_pipe_stall),
    .perf_amo_ops    (perf_amo_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (|dmem_bus.dmem_rmask) rd_issues++;
    if (|dmem_bus.dmem_wmask) wr_issues++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_resp(input logic [31:0] d);
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = d;
  endtask

  task automatic mem_idle();
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = '0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq(tag, {60'd0, dmem_bus.dmem_rmask | dmem_bus.dmem_wmask}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    pipe_rmask = '0; pipe_wmask = '0; pipe_addr = '0; pipe_wdata = '0;
    amo_read = 1'b0; amo_write = 1'b0; amo_addr = '0; amo_wdata = '0;
    mem_idle();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_masks", {dmem_bus.dmem_rmask, dmem_bus.dmem_wmask}, 64'd0);
    check_eq("rst_addr", dmem_bus.dmem_addr, 64'd0);
    check_eq("rst_wdata", dmem_bus.dmem_wdata, 64'd0);
    check_eq("rst_resp", {pipe_resp, amo_resp}, 64'd0);
    check_eq("rst_rdata", {pipe_rdata, amo_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // T1: pipe load, memory answers 3 cycles after issue
    @(negedge clk);
    pipe_addr = 32'h100; pipe_rmask = 4'hF; rd0 = rd_issues;
    @(negedge clk); #1;
    check_eq("t1_rmask", dmem_bus.dmem_rmask, 64'hF);
    check_eq("t1_addr", dmem_bus.dmem_addr, 64'h100);
    check_eq("t1_wmask", dmem_bus.dmem_wmask, 64'h0);
    repeat (2) begin
      @(negedge clk); #1;
      check_quiet("t1_wait_mask");
      check_eq("t1_wait_resp", pipe_resp, 64'd0);
    end
    @(negedge clk);
    mem_resp(32'hDEADBEEF); #1;
    check_eq("t1_pipe_resp", pipe_resp, 64'd1);
    check_eq("t1_pipe_rdata", pipe_rdata, 64'hDEADBEEF);
    check_eq("t1_amo_resp", amo_resp, 64'd0);
    check_eq("t1_amo_rdata", amo_rdata, 64'd0);
    @(negedge clk);
    mem_idle(); pipe_rmask = '0; pipe_addr = '0; #1;
    check_eq("t1_cool_resp", pipe_resp, 64'd0);
    @(negedge clk);
    check_eq("t1_issue_count", rd_issues - rd0, 64'd1);

    // T2: AMO read then write-back
    rd0 = rd_issues; wr0 = wr_issues;
    @(negedge clk);
    amo_addr = 32'h200; amo_read = 1'b1;
    @(negedge clk); #1;
    check_eq("t2_rd_rmask", dmem_bus.dmem_rmask, 64'hF);
    check_eq("t2_rd_addr", dmem_bus.dmem_addr, 64'h200);
    @(negedge clk);
    mem_resp(32'd5); #1;
    check_eq("t2_rd_resp", amo_resp, 64'd1);
    check_eq("t2_rd_rdata", amo_rdata, 64'd5);
    check_eq("t2_rd_pipe_resp", pipe_resp, 64'd0);
    @(negedge clk);
    mem_idle(); amo_read = 1'b0;
    @(negedge clk);
    amo_write = 1'b1; amo_wdata = 32'h9;
    @(negedge clk); #1;
    check_eq("t2_wr_wmask", dmem_bus.dmem_wmask, 64'hF);
    check_eq("t2_wr_rmask", dmem_bus.dmem_rmask, 64'h0);
    check_eq("t2_wr_wdata", dmem_bus.dmem_wdata, 64'h9);
    check_eq("t2_wr_addr", dmem_bus.dmem_addr, 64'h200);
    @(negedge clk);
    mem_resp(32'd0); #1;
    check_eq("t2_wr_resp", amo_resp, 64'd1);
    @(negedge clk);
    mem_idle(); amo_write = 1'b0; amo_addr = '0;
    @(negedge clk);
    check_eq("t2_rd_count", rd_issues - rd0, 64'd1);
    check_eq("t2_wr_count", wr_issues - wr0, 64'd1);

    // T3: pipe store (with stray rmask) raised while AMO holds the lock
    @(negedge clk);
    amo_addr = 32'h240; amo_read = 1'b1;
    @(negedge clk); #1;
    check_eq("t3_rd_rmask", dmem_bus.dmem_rmask, 64'hF);
    @(negedge clk);
    mem_resp(32'h11);
    @(negedge clk);
    mem_idle(); amo_read = 1'b0;
    pipe_addr = 32'h300; pipe_wmask = 4'hF; pipe_rmask = 4'h3; pipe_wdata = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk); #1;
      check_quiet("t3_lock_stall");
    end
    amo_write = 1'b1; amo_wdata = 32'h12;
    @(negedge clk); #1;
    check_eq("t3_amo_wmask", dmem_bus.dmem_wmask, 64'hF);
    check_eq("t3_amo_wdata", dmem_bus.dmem_wdata, 64'h12);
    check_eq("t3_amo_addr", dmem_bus.dmem_addr, 64'h240);
    @(negedge clk);
    mem_resp(32'd0); #1;
    check_eq("t3_amo_resp", amo_resp, 64'd1);
    check_eq("t3_pipe_noresp", pipe_resp, 64'd0);
    @(negedge clk);
    mem_idle(); amo_write = 1'b0; #1;
    check_quiet("t3_cool_quiet");
    @(negedge clk); #1;
    check_quiet("t3_idle_quiet");
    @(negedge clk); #1;
    check_eq("t3_st_wmask", dmem_bus.dmem_wmask, 64'hF);
    check_eq("t3_st_rmask", dmem_bus.dmem_rmask, 64'h0);
    check_eq("t3_st_wdata", dmem_bus.dmem_wdata, 64'hCAFEF00D);
    check_eq("t3_st_addr", dmem_bus.dmem_addr, 64'h300);
    mem_resp(32'd0); #1;
    check_eq("t3_st_resp", pipe_resp, 64'd1);
    check_eq("t3_st_amo_resp", amo_resp, 64'd0);
    @(negedge clk);
    mem_idle(); pipe_wmask = '0; pipe_rmask = '0;
    @(negedge clk);

    // T4: AMO read and pipe load raised together
    @(negedge clk);
    amo_addr = 32'h400; amo_read = 1'b1; pipe_addr = 32'h500; pipe_rmask = 4'hF;
    @(negedge clk); #1;
    check_eq("t4_amo_rmask", dmem_bus.dmem_rmask, 64'hF);
    check_eq("t4_amo_addr", dmem_bus.dmem_addr, 64'h400);
    @(negedge clk);
    mem_resp(32'h21); #1;
    check_eq("t4_amo_resp", amo_resp, 64'd1);
    check_eq("t4_pipe_noresp", pipe_resp, 64'd0);
    check_eq("t4_pipe_rdata0", pipe_rdata, 64'd0);
    @(negedge clk);
    mem_idle(); amo_read = 1'b0;
    @(negedge clk); #1;
    check_quiet("t4_lock_quiet");
    amo_write = 1'b1; amo_wdata = 32'h22;
    @(negedge clk); #1;
    check_eq("t4_amo_wmask", dmem_bus.dmem_wmask, 64'hF);
    check_eq("t4_amo_waddr", dmem_bus.dmem_addr, 64'h400);
    @(negedge clk);
    mem_resp(32'd0); #1;
    check_eq("t4_amo_wresp", amo_resp, 64'd1);
    check_eq("t4_pipe_noresp2", pipe_resp, 64'd0);
    @(negedge clk);
    mem_idle(); amo_write = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("t4_pipe_rmask", dmem_bus.dmem_rmask, 64'hF);
    check_eq("t4_pipe_addr", dmem_bus.dmem_addr, 64'h500);
    @(negedge clk);
    mem_resp(32'h5A5A); #1;
    check_eq("t4_pipe_resp", pipe_resp, 64'd1);
    check_eq("t4_pipe_rdata", pipe_rdata, 64'h5A5A);
    @(negedge clk);
    mem_idle(); pipe_rmask = '0;
    @(negedge clk);

    // T5: reset while the AMO write-back waits, stale response afterwards
    @(negedge clk);
    amo_addr = 32'h600; amo_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_resp(32'h1);
    @(negedge clk);
    mem_idle(); amo_read = 1'b0;
    @(negedge clk);
    amo_write = 1'b1; amo_wdata = 32'h33;
    @(negedge clk); #1;
    check_eq("t5_amo_wmask", dmem_bus.dmem_wmask, 64'hF);
    @(negedge clk);
    reset = 1'b1; amo_write = 1'b0; amo_addr = '0; #1;
    check_quiet("t5_rst_quiet");
    check_eq("t5_rst_resp", {pipe_resp, amo_resp}, 64'd0);
    @(negedge clk);
    reset = 1'b0; mem_resp(32'h1234); #1;
    check_eq("t5_stale_resp", {pipe_resp, amo_resp}, 64'd0);
    check_eq("t5_stale_rdata", {pipe_rdata, amo_rdata}, 64'd0);
    @(negedge clk);
    mem_idle(); pipe_addr = 32'h703; pipe_rmask = 4'hF;
    @(negedge clk); #1;
    check_eq("t5_unlock_rmask", dmem_bus.dmem_rmask, 64'hF);
    check_eq("t5_unlock_addr", dmem_bus.dmem_addr, 64'h700);
    mem_resp(32'h77); #1;
    check_eq("t5_unlock_resp", pipe_resp, 64'd1);
    @(negedge clk);
    mem_idle(); pipe_rmask = '0;
    @(negedge clk);

    // T6: zero-wait memory, pipe load held continuously
    @(negedge clk);
    pipe_addr = 32'h800; pipe_rmask = 4'hF; rd0 = rd_issues;
    for (int k = 0; k < 12; k++) begin
      logic issued;
      @(negedge clk); #1;
      issued = |dmem_bus.dmem_rmask;
      check_eq($sformatf("t6_issue_%0d", k), issued, (k % 3 == 0) ? 64'd1 : 64'd0);
      if (issued) begin
        mem_resp(32'h800 + k); #1;
        check_eq($sformatf("t6_resp_%0d", k), pipe_resp, 64'd1);
        check_eq($sformatf("t6_rdata_%0d", k), pipe_rdata, 64'h800 + k);
      end else begin
        mem_idle();
      end
      if (k == 11) pipe_rmask = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("t6_issue_count", rd_issues - rd0, 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
